// File: rtl/firebird7_in_gate1_tessent_data_mux_mc.sv
// Multi-channel IJTAG override mux with glitch-free switchover.
// Each lane selects functional or IJTAG data. A select change first freezes the
// lane output on a hold register for SETTLE cycles, then the new source appears.
// A shared capture register snapshots all lanes' data_out for readback via the TDR.
//
// Ports:
//   ijtag_tck           clock, rising edge
//   ijtag_reset         asynchronous active-low reset
//   ijtag_select        per-lane request (1 = IJTAG data, 0 = functional data)
//   functional_data_in  lane k at [k*WIDTH +: WIDTH]
//   ijtag_data_in       lane k at [k*WIDTH +: WIDTH]
//   ijtag_capture_en    load capture_data from data_out
//   data_out            muxed lane data
//   ijtag_active        lane is in the IJTAG state
//   switching           lane is in a hold state
//   capture_data        registered snapshot of data_out
module firebird7_in_gate1_tessent_data_mux_mc #(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SETTLE   = 2
) (
  input  logic                      ijtag_tck,
  input  logic                      ijtag_reset,
  input  logic [CHANNELS-1:0]       ijtag_select,
  input  logic [CHANNELS*WIDTH-1:0] functional_data_in,
  input  logic [CHANNELS*WIDTH-1:0] ijtag_data_in,
  input  logic                      ijtag_capture_en,
  output logic [CHANNELS*WIDTH-1:0] data_out,
  output logic [CHANNELS-1:0]       ijtag_active,
  output logic [CHANNELS-1:0]       switching,
  output logic [CHANNELS*WIDTH-1:0] capture_data
);

  localparam int unsigned CntW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int unsigned CntLoadInt = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam logic [CntW-1:0] CntLoad = CntW'(CntLoadInt);
  localparam bit HasHold = (SETTLE > 0);

  typedef enum logic [1:0] {StFunc, StHoldI, StIjtag, StHoldF} state_e;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    state_e            state_q, state_d;
    logic [WIDTH-1:0]  hold_q, hold_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  func_k, ijtag_k;
    logic              sel_k;

    assign func_k  = functional_data_in[k*WIDTH +: WIDTH];
    assign ijtag_k = ijtag_data_in[k*WIDTH +: WIDTH];
    assign sel_k   = ijtag_select[k];

    always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        StFunc: begin
          if (sel_k) begin
            if (HasHold) begin
              state_d = StHoldI;
              hold_d  = func_k;
              cnt_d   = CntLoad;
            end else begin
              state_d = StIjtag;
            end
          end
        end
        StHoldI: begin
          if (!sel_k) begin
            // Request reverted: keep the frozen value and restart the count.
            state_d = StHoldF;
            cnt_d   = CntLoad;
          end else if (cnt_q == '0) begin
            state_d = StIjtag;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        StIjtag: begin
          if (!sel_k) begin
            if (HasHold) begin
              state_d = StHoldF;
              hold_d  = ijtag_k;
              cnt_d   = CntLoad;
            end else begin
              state_d = StFunc;
            end
          end
        end
        StHoldF: begin
          if (sel_k) begin
            state_d = StHoldI;
            cnt_d   = CntLoad;
          end else if (cnt_q == '0) begin
            state_d = StFunc;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        default: state_d = StFunc;
      endcase
    end

    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
      if (!ijtag_reset) begin
        state_q <= StFunc;
        hold_q  <= '0;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        hold_q  <= hold_d;
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      unique case (state_q)
        StIjtag:          data_out[k*WIDTH +: WIDTH] = ijtag_k;
        StHoldI, StHoldF: data_out[k*WIDTH +: WIDTH] = hold_q;
        default:          data_out[k*WIDTH +: WIDTH] = func_k;
      endcase
    end

    assign ijtag_active[k] = (state_q == StIjtag);
    assign switching[k]    = (state_q == StHoldI) || (state_q == StHoldF);
  end

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      capture_data <= '0;
    end else if (ijtag_capture_en) begin
      capture_data <= data_out;
    end
  end

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_mc.sv
module tb_firebird7_in_gate1_tessent_data_mux_mc;

  localparam int W = 3;
  localparam int C = 4;

  logic           tck = 1'b0;
  logic           rst_n;
  logic [C-1:0]   sel, sel_z;
  logic [C*W-1:0] func, ijt;
  logic           cap;
  logic [C*W-1:0] dout, capd, dout_z, capd_z;
  logic [C-1:0]   act, sw, act_z, sw_z;

  int total = 0;
  int bad   = 0;

  always #5 tck = ~tck;

  firebird7_in_gate1_tessent_data_mux_mc #(.WIDTH(W), .CHANNELS(C), .SETTLE(2)) dut (
    .ijtag_tck(tck), .ijtag_reset(rst_n), .ijtag_select(sel),
    .functional_data_in(func), .ijtag_data_in(ijt), .ijtag_capture_en(cap),
    .data_out(dout), .ijtag_active(act), .switching(sw), .capture_data(capd)
  );

  firebird7_in_gate1_tessent_data_mux_mc #(.WIDTH(W), .CHANNELS(C), .SETTLE(0)) dut0 (
    .ijtag_tck(tck), .ijtag_reset(rst_n), .ijtag_select(sel_z),
    .functional_data_in(func), .ijtag_data_in(ijt), .ijtag_capture_en(1'b0),
    .data_out(dout_z), .ijtag_active(act_z), .switching(sw_z), .capture_data(capd_z)
  );

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  sel;
    logic [11:0] func;
    logic [11:0] ijt;
    logic        cap;
    logic [11:0] eout;
    logic [3:0]  eact;
    logic [3:0]  esw;
    logic [11:0] ecap;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] s, input logic [11:0] f, input logic [11:0] i,
                              input logic c, input logic [11:0] o, input logic [3:0] a,
                              input logic [3:0] w, input logic [11:0] cd);
    vec_t v;
    v.sel = s; v.func = f; v.ijt = i; v.cap = c;
    v.eout = o; v.eact = a; v.esw = w; v.ecap = cd;
    return v;
  endfunction

  // Lane order in concatenations: {lane3, lane2, lane1, lane0}
  localparam logic [11:0] F1  = {3'b100, 3'b001, 3'b011, 3'b101};
  localparam logic [11:0] F2  = {3'b100, 3'b001, 3'b000, 3'b101};
  localparam logic [11:0] F3  = {3'b100, 3'b111, 3'b000, 3'b101};
  localparam logic [11:0] F4  = {3'b010, 3'b111, 3'b000, 3'b101};
  localparam logic [11:0] F5  = {3'b010, 3'b111, 3'b000, 3'b011};
  localparam logic [11:0] I1  = {3'b111, 3'b010, 3'b110, 3'b000};
  localparam logic [11:0] O1  = {3'b100, 3'b001, 3'b011, 3'b101};
  localparam logic [11:0] O4  = {3'b100, 3'b001, 3'b110, 3'b101};
  localparam logic [11:0] O10 = {3'b100, 3'b111, 3'b110, 3'b101};
  localparam logic [11:0] O11 = {3'b010, 3'b111, 3'b110, 3'b101};
  localparam logic [11:0] O14 = {3'b111, 3'b111, 3'b110, 3'b101};

  vec_t vecs[18];

  initial begin
    // lane1 FUNC->IJTAG with data changed under the hold
    vecs[0]  = mk(4'b0000, F1, I1, 1'b0, O1,  4'b0000, 4'b0000, 12'd0);
    vecs[1]  = mk(4'b0010, F1, I1, 1'b0, O1,  4'b0000, 4'b0000, 12'd0);
    vecs[2]  = mk(4'b0010, F2, I1, 1'b0, O1,  4'b0000, 4'b0010, 12'd0);
    vecs[3]  = mk(4'b0010, F2, I1, 1'b0, O1,  4'b0000, 4'b0010, 12'd0);
    vecs[4]  = mk(4'b0010, F2, I1, 1'b1, O4,  4'b0010, 4'b0000, 12'd0);
    vecs[5]  = mk(4'b0010, F2, I1, 1'b0, O4,  4'b0010, 4'b0000, O4);
    // lane2 request reverted during HOLD_I
    vecs[6]  = mk(4'b0110, F2, I1, 1'b0, O4,  4'b0010, 4'b0000, O4);
    vecs[7]  = mk(4'b0010, F3, I1, 1'b0, O4,  4'b0010, 4'b0100, O4);
    vecs[8]  = mk(4'b0010, F3, I1, 1'b0, O4,  4'b0010, 4'b0100, O4);
    vecs[9]  = mk(4'b0010, F3, I1, 1'b0, O4,  4'b0010, 4'b0100, O4);
    vecs[10] = mk(4'b0010, F3, I1, 1'b0, O10, 4'b0010, 4'b0000, O4);
    // lane3 capture on the HOLD_I exit edge
    vecs[11] = mk(4'b1010, F4, I1, 1'b0, O11, 4'b0010, 4'b0000, O4);
    vecs[12] = mk(4'b1010, F4, I1, 1'b0, O11, 4'b0010, 4'b1000, O4);
    vecs[13] = mk(4'b1010, F4, I1, 1'b1, O11, 4'b0010, 4'b1000, O4);
    vecs[14] = mk(4'b1010, F4, I1, 1'b0, O14, 4'b1010, 4'b0000, O11);
    // lane0 into HOLD_F, reset applied afterwards
    vecs[15] = mk(4'b1011, F4, I1, 1'b0, O14, 4'b1010, 4'b0000, O11);
    vecs[16] = mk(4'b1010, F4, I1, 1'b0, O14, 4'b1010, 4'b0001, O11);
    vecs[17] = mk(4'b1010, F5, I1, 1'b0, O14, 4'b1010, 4'b0001, O11);

    rst_n = 1'b0; sel = '0; sel_z = '0; cap = 1'b0;
    func = F1; ijt = I1;
    #2;
    chk("reset out", dout, F1);
    chk("reset cap", capd, 12'd0);
    chk("reset act", {8'd0, act}, 12'd0);
    chk("reset sw", {8'd0, sw}, 12'd0);
    @(posedge tck); #1;
    chk("reset out held", dout, F1);
    rst_n = 1'b1;
    @(posedge tck); #1;

    for (int i = 0; i < 18; i++) begin
      sel = vecs[i].sel; func = vecs[i].func; ijt = vecs[i].ijt; cap = vecs[i].cap;
      #1;
      chk($sformatf("v%0d out", i), dout, vecs[i].eout);
      chk($sformatf("v%0d act", i), {8'd0, act}, {8'd0, vecs[i].eact});
      chk($sformatf("v%0d sw", i), {8'd0, sw}, {8'd0, vecs[i].esw});
      chk($sformatf("v%0d cap", i), capd, vecs[i].ecap);
      if (i != 17) begin
        @(posedge tck); #1;
      end
    end

    // Asynchronous reset while lane0 is in HOLD_F
    rst_n = 1'b0;
    #1;
    chk("midreset out", dout, F5);
    chk("midreset sw", {8'd0, sw}, 12'd0);
    chk("midreset act", {8'd0, act}, 12'd0);
    chk("midreset cap", capd, 12'd0);
    @(posedge tck); #1;
    sel = '0; cap = 1'b0;
    rst_n = 1'b1;
    @(posedge tck); #1;
    chk("post rst sw", {8'd0, sw}, 12'd0);
    // Fresh transition must take the full SETTLE+1 edges
    sel = 4'b0001;
    @(posedge tck); #1;
    chk("post e1 sw", {8'd0, sw}, 12'h001);
    chk("post e1 out", dout, {F5[11:3], 3'b011});
    func = {F5[11:3], 3'b110};
    @(posedge tck); #1;
    chk("post e2 sw", {8'd0, sw}, 12'h001);
    chk("post e2 out", dout, {F5[11:3], 3'b011});
    @(posedge tck); #1;
    chk("post e3 act", {8'd0, act}, 12'h001);
    chk("post e3 out", dout, {F5[11:3], 3'b000});
    sel = '0;

    // SETTLE=0: output follows the select registered one edge earlier
    func = F5; ijt = I1;
    begin
      logic [3:0]  prev;
      logic [11:0] exp;
      prev = '0;
      for (int i = 0; i < 8; i++) begin
        sel_z = (i % 2 == 0) ? 4'b1111 : 4'b0000;
        if (i == 5) sel_z = 4'b0101;
        #1;
        for (int k = 0; k < C; k++) exp[k*W +: W] = prev[k] ? ijt[k*W +: W] : func[k*W +: W];
        chk($sformatf("z%0d out", i), dout_z, exp);
        chk($sformatf("z%0d act", i), {8'd0, act_z}, {8'd0, prev});
        chk($sformatf("z%0d sw", i), {8'd0, sw_z}, 12'd0);
        @(posedge tck); #1;
        prev = sel_z;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
